// File: rtl/pit_pkg.sv
// Shared definitions for the programmable interval timer: register map, CTRL/STATUS
// bit positions and the timer state encoding.
package pit_pkg;

    localparam int unsigned DataW = 32;

    // Register addresses
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrReload = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    // CTRL bit positions
    localparam int unsigned CtrlEn   = 0;
    localparam int unsigned CtrlIe   = 1;
    localparam int unsigned CtrlAr   = 2;
    localparam int unsigned CtrlBits = 3;

    // STATUS bit positions
    localparam int unsigned StatusExp = 0;

    typedef enum logic [1:0] {
        StStop = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } pit_state_e;

endpackage

// File: rtl/pit_presc.sv
// Timer prescaler: free-running modulo-PRESCALE counter that emits a one-cycle tick
// on its terminal value while enabled.
module pit_presc #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(PRESCALE);
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i & (cnt_q == CntMax);

endmodule

// File: rtl/pit.sv
// Programmable interval timer with a four-register bus interface, one-shot or
// auto-reload countdown, sticky expiry flag and registered level interrupt.
module pit
    import pit_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [DataW-1:0] data_in,
    output logic [DataW-1:0] data_out,
    output logic             ack,
    output logic             irq
);

    logic [CtrlBits-1:0] ctrl_q, ctrl_d;
    logic [DataW-1:0]    reload_q, reload_d;
    logic [DataW-1:0]    count_q, count_d;
    logic                exp_q, exp_d;
    logic                irq_q;
    pit_state_e          state_q, state_d;

    logic wr_ctrl, wr_reload, wr_count, wr_status;
    logic presc_clr, tick;
    logic run_tick, expire;

    assign wr_ctrl   = stb & we & (addr == AddrCtrl);
    assign wr_reload = stb & we & (addr == AddrReload);
    assign wr_count  = stb & we & (addr == AddrCount);
    assign wr_status = stb & we & (addr == AddrStatus);

    // Restart the prescaler phase only on a genuine 0->1 transition of EN.
    assign presc_clr = wr_ctrl & data_in[CtrlEn] & ~ctrl_q[CtrlEn];

    pit_presc #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ctrl_q[CtrlEn]),
        .clr_i (presc_clr),
        .tick_o(tick)
    );

    // A bus write to COUNT swallows a coincident tick; a zero count never expires.
    assign run_tick = (state_q == StRun) & tick & (count_q != '0) & ~wr_count;
    assign expire   = run_tick & (count_q == DataW'(1));

    always_comb begin
        ctrl_d   = ctrl_q;
        reload_d = reload_q;
        count_d  = count_q;
        exp_d    = exp_q;

        if (wr_ctrl) begin
            ctrl_d = data_in[CtrlBits-1:0];
        end
        if (wr_reload) begin
            reload_d = data_in;
        end

        if (wr_count) begin
            count_d = data_in;
        end else if (expire) begin
            count_d = ctrl_q[CtrlAr] ? reload_q : '0;
        end else if (run_tick) begin
            count_d = count_q - DataW'(1);
        end

        // Set has priority over a simultaneous write-1-to-clear.
        if (wr_status && data_in[StatusExp]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop: begin
                if (ctrl_d[CtrlEn]) begin
                    state_d = (count_d != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (!ctrl_d[CtrlEn]) begin
                    state_d = StStop;
                end else if (count_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!ctrl_d[CtrlEn]) begin
                    state_d = StStop;
                end else if (count_d != '0) begin
                    state_d = StRun;
                end
            end
            default: state_d = StStop;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            exp_q    <= 1'b0;
            irq_q    <= 1'b0;
            state_q  <= StStop;
        end else begin
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            irq_q    <= exp_q & ctrl_q[CtrlIe];
            state_q  <= state_d;
        end
    end

    always_comb begin
        data_out = '0;
        unique case (addr)
            AddrCtrl:   data_out = {{(DataW - CtrlBits){1'b0}}, ctrl_q};
            AddrReload: data_out = reload_q;
            AddrCount:  data_out = count_q;
            AddrStatus: data_out = {{(DataW - 1){1'b0}}, exp_q};
            default:    data_out = '0;
        endcase
    end

    assign ack = stb;
    assign irq = irq_q;

endmodule

// File: tb/tb_pit.sv
// Self-checking bench for pit with PRESCALE=4: expected read data is queued when a
// read is issued and popped when the combinational read data is sampled.
module tb_pit;
    import pit_pkg::*;

    localparam int unsigned Prescale = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    pit #(
        .PRESCALE(Prescale)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .stb     (stb),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .ack     (ack),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    // Advance to just after the next rising edge(s).
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr    = a;
        data_in = d;
        we      = 1'b1;
        stb     = 1'b1;
        step(1);
        stb     = 1'b0;
        we      = 1'b0;
    endtask

    // Zero-wait read within the current cycle; does not consume a clock edge.
    task automatic peek(input logic [1:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        addr = a;
        we   = 1'b0;
        stb  = 1'b1;
        #1;
        check_eq({tag, "_ack"}, {31'd0, ack}, 32'd1);
        check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
        stb = 1'b0;
    endtask

    initial begin
        // Reset: registers read zero and ack tracks stb even while rst is high
        step(2);
        peek(AddrCtrl, 32'd0, "rst_ctrl");
        peek(AddrReload, 32'd0, "rst_reload");
        peek(AddrCount, 32'd0, "rst_count");
        #1;
        check_eq("rst_ack_idle", {31'd0, ack}, 32'd0);
        rst = 1'b0;
        step(1);
        peek(AddrStatus, 32'd0, "rst_status");
        peek(AddrCount, 32'd0, "rst_count2");
        check_eq("rst_irq", {31'd0, irq}, 32'd0);

        // One-shot countdown with IE
        wr(AddrReload, 32'd3);
        wr(AddrCount, 32'd3);
        wr(AddrCtrl, 32'h3);
        peek(AddrReload, 32'd3, "os_reload");
        for (int k = 0; k < 16; k++) begin
            peek(AddrCount, (k < 12) ? 32'(3 - k / 4) : 32'd0, "os_count");
            peek(AddrStatus, {31'd0, k >= 12}, "os_exp");
            check_eq("os_irq", {31'd0, irq}, {31'd0, k >= 13});
            step(1);
        end
        peek(AddrCtrl, 32'h3, "os_ctrl");

        // Auto-reload; clear EXP between expiries, then clear exactly on an expiry
        wr(AddrCtrl, 32'h0);
        wr(AddrStatus, 32'h1);
        wr(AddrCount, 32'd3);
        wr(AddrCtrl, 32'hffff_fff7);
        peek(AddrCtrl, 32'h7, "ar_ctrl_mask");
        for (int k = 0; k < 39; k++) begin
            peek(AddrCount, 32'(3 - (k % 12) / 4), "ar_count");
            peek(AddrStatus, {31'd0, (k >= 12 && k <= 14) || k >= 24}, "ar_exp");
            check_eq("ar_irq", {31'd0, irq}, {31'd0, (k >= 13 && k <= 15) || k >= 25});
            if (k == 14 || k == 35) begin
                wr(AddrStatus, 32'h1);
            end else begin
                step(1);
            end
        end

        // COUNT write on a tick wins; EN clear freezes; re-enable restarts prescaler
        wr(AddrCtrl, 32'h0);
        wr(AddrStatus, 32'h1);
        wr(AddrCount, 32'd20);
        wr(AddrCtrl, 32'h3);
        for (int k = 0; k < 14; k++) begin
            peek(AddrCount, (k < 4) ? 32'd20 : (k < 8) ? 32'd19 : (k < 12) ? 32'd10 : 32'd9,
                 "wt_count");
            if (k == 7) begin
                wr(AddrCount, 32'd10);
            end else if (k == 13) begin
                wr(AddrCtrl, 32'h0);
            end else begin
                step(1);
            end
        end
        for (int k = 0; k < 20; k++) begin
            peek(AddrCount, 32'd9, "frz_count");
            step(1);
        end
        wr(AddrCtrl, 32'h3);
        for (int k = 0; k < 5; k++) begin
            peek(AddrCount, (k < 4) ? 32'd9 : 32'd8, "reen_count");
            step(1);
        end

        // Reset just before an expiry abandons the count
        wr(AddrCtrl, 32'h0);
        wr(AddrCount, 32'd2);
        wr(AddrStatus, 32'h1);
        wr(AddrCtrl, 32'h3);
        for (int k = 0; k < 7; k++) begin
            peek(AddrCount, (k < 4) ? 32'd2 : 32'd1, "pre_rst_count");
            if (k == 6) begin
                rst = 1'b1;
                step(2);
                rst = 1'b0;
            end else begin
                step(1);
            end
        end
        for (int k = 0; k < 6; k++) begin
            peek(AddrCtrl, 32'd0, "mid_rst_ctrl");
            peek(AddrReload, 32'd0, "mid_rst_reload");
            peek(AddrCount, 32'd0, "mid_rst_count");
            peek(AddrStatus, 32'd0, "mid_rst_exp");
            check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pit.md
PIT -- requirements
Module: pit

Interface
REQ-001 Parameter PRESCALE, default 50000, SHALL set clk cycles per timer tick (1 ms at 50 MHz); legal range 2..65536.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stb  input  1  bus strobe; one access per cycle while high.
REQ-005 we  input  1  write enable, qualified by stb.
REQ-006 addr  input  2  register select: 0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS.
REQ-007 data_in  input  32  write data.
REQ-008 data_out  output  32  read data, combinational from addr.
REQ-009 ack  output  1  SHALL equal stb (zero wait states, reads and writes).
REQ-010 irq  output  1  interrupt request, level, registered.

Function
REQ-011 CTRL: bit0 EN, bit1 IE, bit2 AR (auto-reload); bits 31:3 SHALL read 0 and ignore writes.
REQ-012 RELOAD: 32-bit read/write reload value.
REQ-013 COUNT: read returns the live counter; write loads the counter directly.
REQ-014 STATUS: bit0 EXP; writing 1 to bit0 SHALL clear EXP, writing 0 SHALL have no effect; bits 31:1 read 0.
REQ-015 Prescaler: counts 0..PRESCALE-1 while EN=1 and wraps; tick is a one-cycle pulse in the cycle the prescaler equals PRESCALE-1.
REQ-016 Prescaler SHALL hold while EN=0, and SHALL clear to 0 in the cycle a CTRL write changes EN from 0 to 1.
REQ-017 State machine: STOP (EN=0), RUN (EN=1, count>0), DONE (EN=1, count=0, AR=0).
REQ-018 RUN on tick: count>1 -> count-1; count=1 -> EXP set, then count<=RELOAD if AR=1 (stay RUN, or DONE if RELOAD=0), else count<=0 and go DONE.
REQ-019 DONE: count holds at 0, no further EXP sets; a COUNT write of nonzero value SHALL return to RUN.
REQ-020 RUN with count=0 (e.g. COUNT written 0) SHALL behave as DONE; a zero count never sets EXP.
REQ-021 EN cleared in any state SHALL go STOP, freezing count and prescaler; EXP is unaffected.
REQ-022 irq SHALL equal registered (EXP and IE), updating the cycle after EXP or IE changes.
REQ-023 COUNT write coinciding with a tick: the write SHALL win; that tick is lost; prescaler unaffected.
REQ-024 EXP clear coinciding with an expiry: the set SHALL win (EXP stays 1).
REQ-025 RELOAD write coinciding with a reloading expiry: the old RELOAD value SHALL be loaded.
REQ-026 Counter arithmetic is 32-bit unsigned; no wrap below 0 ever occurs.

Reset
REQ-027 On rst: CTRL=0, RELOAD=0, COUNT=0, EXP=0, prescaler=0, state STOP, irq=0.
REQ-028 rst mid-count SHALL abandon the count; no EXP or irq SHALL result from it.
REQ-029 data_out and ack remain combinational during reset (ack=stb, data_out reflects reset values).

Structure
REQ-030 Shared package SHALL hold register address constants, CTRL bit positions and the state encoding.
REQ-031 One sub-module pit_presc (prescaler counter + tick output, PRESCALE parameter) SHALL be instantiated; the rest stays in pit.

Verification (bench uses PRESCALE=4)
REQ-032 Reset, read all four registers -> all read 0, irq=0, ack follows stb every cycle.
REQ-033 RELOAD=3, COUNT=3, CTRL=0x3 -> count 3,2,1,0 at ticks every 4 cycles; EXP=1 after 12 cycles; irq=1 one cycle later; count stays 0.
REQ-034 Same with CTRL=0x7 -> EXP at cycle 12, count reloads 3, second expiry at cycle 24; write STATUS=1 between -> irq drops next cycle.
REQ-035 STATUS write 1 in the exact cycle of an expiry -> EXP remains 1, irq stays high.
REQ-036 COUNT write 10 in a tick cycle -> COUNT reads 10 next cycle (not 9); EN cleared mid-count -> COUNT frozen over 20 cycles; re-enable -> next tick 4 cycles later.
REQ-037 rst asserted one cycle before an expiry -> no EXP, irq stays 0, all registers 0.
